// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter/sequencer for the data memory; `DM_RR_EN selects round-robin tie-break
module dm_arbiter #(
  parameter int AW = 12,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] dm_direccion,
  output logic [DW-1:0] dm_dataWrite,
  output logic          dm_memWr,
  input  logic [DW-1:0] dm_dataRead,
  output logic          busy,
  output logic          owner
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state, nextState;
  logic weQ;
  logic grant1;
  logic load;
  logic weWin;
  logic ackNext0;
  logic ackNext1;
  logic capture;
`ifdef DM_RR_EN
  logic lastGrant;
  assign grant1 = req1 & (~req0 | ~lastGrant);
  // remember the most recent winner so the other port takes the next tie
  always_ff @(posedge clk)
    if (!rst_n) lastGrant <= 1'b1;
    else if (load) lastGrant <= grant1;
`else
  assign grant1 = req1 & ~req0;
`endif
  // state register
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nextState;
  // next-state: a grant in IDLE runs ACC then DONE, then back to IDLE
  always_comb begin
    nextState = IDLE;
    nextState = (state == IDLE) ? ((req0 | req1) ? ACC : IDLE) :
                (state == ACC)  ? DONE : IDLE;
  end
  // decode of what the registers pick up at the end of this cycle
  always_comb begin
    load = (state == IDLE) & (req0 | req1);
    weWin = grant1 ? we1 : we0;
    ackNext0 = (state == ACC) & ~owner;
    ackNext1 = (state == ACC) & owner;
    capture = (state == ACC) & ~weQ;
  end
  // DM drive, ack and read-data registers; memWr is only ever a flop output
  always_ff @(posedge clk)
    if (!rst_n) begin
      dm_memWr <= 1'b0;
      dm_direccion <= '0;
      dm_dataWrite <= '0;
      weQ <= 1'b0;
      owner <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      dm_memWr <= load & weWin;
      ack0 <= ackNext0;
      ack1 <= ackNext1;
      if (load) begin
        dm_direccion <= grant1 ? addr1 : addr0;
        dm_dataWrite <= grant1 ? wdata1 : wdata0;
        weQ <= weWin;
        owner <= grant1;
      end
      if (capture & ~owner) rdata0 <= dm_dataRead;
      if (capture & owner) rdata1 <= dm_dataRead;
    end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed vector bench for dm_arbiter with a behavioural data memory
module tb_dm_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic req0, we0, req1, we1;
  logic [11:0] addr0, addr1;
  logic [63:0] wdata0, wdata1;
  logic ack0, ack1, dm_memWr, busy, owner;
  logic [63:0] rdata0, rdata1, dm_dataWrite, dm_dataRead;
  logic [11:0] dm_direccion;
  logic [63:0] mem [4096];
  int checks = 0;
  int errors = 0;
  localparam logic [63:0] DV = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef DM_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct {
    logic r0; logic w0; logic [11:0] a0; logic [63:0] d0;
    logic r1; logic w1; logic [11:0] a1; logic [63:0] d1;
    logic m; logic [11:0] dir; logic k0; logic k1; logic [63:0] q0; logic [63:0] q1;
  } vec_t;
  vec_t vt [10];

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .rdata0(rdata0), .ack1(ack1), .rdata1(rdata1),
    .dm_direccion(dm_direccion), .dm_dataWrite(dm_dataWrite), .dm_memWr(dm_memWr),
    .dm_dataRead(dm_dataRead), .busy(busy), .owner(owner)
  );

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 64'(i) * 64'h101;
    forever begin
      @(posedge clk);
      if (dm_memWr) mem[dm_direccion] <= dm_dataWrite;
    end
  end
  assign dm_dataRead = mem[dm_direccion];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic runVec(input vec_t v, input string tag);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    @(negedge clk);
    chk({tag, " memWr"}, 64'(dm_memWr), 64'(v.m));
    chk({tag, " direccion"}, 64'(dm_direccion), 64'(v.dir));
    chk({tag, " busy"}, 64'(busy), 64'd1);
    @(negedge clk);
    chk({tag, " ack0"}, 64'(ack0), 64'(v.k0));
    chk({tag, " ack1"}, 64'(ack1), 64'(v.k1));
    chk({tag, " rdata0"}, rdata0, v.q0);
    chk({tag, " rdata1"}, rdata1, v.q1);
    chk({tag, " memWr done"}, 64'(dm_memWr), 64'd0);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic e0, e1;
    vt[0] = '{1'b1, 1'b1, 12'h00A, 64'h14, 1'b0, 1'b0, 12'h0, 64'h0, 1'b1, 12'h00A, 1'b1, 1'b0, 64'h0, 64'h0};
    vt[1] = '{1'b1, 1'b0, 12'h00A, 64'h0, 1'b0, 1'b0, 12'h0, 64'h0, 1'b0, 12'h00A, 1'b1, 1'b0, 64'h14, 64'h0};
    vt[2] = '{1'b0, 1'b0, 12'h0, 64'h0, 1'b1, 1'b0, 12'h00A, 64'h0, 1'b0, 12'h00A, 1'b0, 1'b1, 64'h14, 64'h14};
    vt[3] = '{1'b0, 1'b0, 12'h0, 64'h0, 1'b1, 1'b1, 12'h123, DV, 1'b1, 12'h123, 1'b0, 1'b1, 64'h14, 64'h14};
    vt[4] = '{1'b1, 1'b0, 12'h123, 64'h0, 1'b0, 1'b0, 12'h0, 64'h0, 1'b0, 12'h123, 1'b1, 1'b0, DV, 64'h14};
`ifdef DM_RR_EN
    vt[5] = '{1'b1, 1'b0, 12'h123, 64'h0, 1'b1, 1'b1, 12'h200, 64'h55, 1'b1, 12'h200, 1'b0, 1'b1, DV, 64'h14};
`else
    vt[5] = '{1'b1, 1'b0, 12'h123, 64'h0, 1'b1, 1'b1, 12'h200, 64'h55, 1'b0, 12'h123, 1'b1, 1'b0, DV, 64'h14};
`endif
    vt[6] = '{1'b0, 1'b0, 12'h0, 64'h0, 1'b1, 1'b0, 12'hFFF, 64'h0, 1'b0, 12'hFFF, 1'b0, 1'b1, DV, 64'h100EFF};
    vt[7] = '{1'b1, 1'b1, 12'hFFF, ONES, 1'b0, 1'b0, 12'h0, 64'h0, 1'b1, 12'hFFF, 1'b1, 1'b0, DV, 64'h100EFF};
    vt[8] = '{1'b1, 1'b0, 12'hFFF, 64'h0, 1'b0, 1'b0, 12'h0, 64'h0, 1'b0, 12'hFFF, 1'b1, 1'b0, ONES, 64'h100EFF};
    vt[9] = '{1'b0, 1'b0, 12'h0, 64'h0, 1'b1, 1'b0, 12'h200, 64'h0, 1'b0, 12'h200, 1'b0, 1'b1, ONES,
              RR ? 64'h55 : 64'h20200};
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req0 = 1'($urandom); we0 = 1'($urandom); addr0 = 12'($urandom); wdata0 = {$urandom, $urandom};
      req1 = 1'($urandom); we1 = 1'($urandom); addr1 = 12'($urandom); wdata1 = {$urandom, $urandom};
      @(negedge clk);
      chk("reset ack0", 64'(ack0), 64'd0);
      chk("reset ack1", 64'(ack1), 64'd0);
      chk("reset memWr", 64'(dm_memWr), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset owner", 64'(owner), 64'd0);
      chk("reset rdata0", rdata0, 64'd0);
      chk("reset rdata1", rdata1, 64'd0);
      chk("reset direccion", 64'(dm_direccion), 64'd0);
      chk("reset dataWrite", dm_dataWrite, 64'd0);
    end
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) runVec(vt[i], $sformatf("vec%0d", i));
    req0 = 1'b1; we0 = 1'b1; addr0 = 12'h0FF; wdata0 = 64'h77;
    @(negedge clk);
    chk("abort memWr acc", 64'(dm_memWr), 64'd1);
    chk("abort direccion", 64'(dm_direccion), 64'h0FF);
    rst_n = 1'b0; req0 = 1'b0;
    @(negedge clk);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort memWr", 64'(dm_memWr), 64'd0);
    chk("abort ack0", 64'(ack0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort ack0 late", 64'(ack0), 64'd0);
    chk("abort ack1 late", 64'(ack1), 64'd0);
    runVec('{1'b1, 1'b1, 12'h0FF, 64'h99, 1'b0, 1'b0, 12'h0, 64'h0, 1'b1, 12'h0FF, 1'b1, 1'b0, 64'h0, 64'h0}, "post wr");
    runVec('{1'b1, 1'b0, 12'h0FF, 64'h0, 1'b0, 1'b0, 12'h0, 64'h0, 1'b0, 12'h0FF, 1'b1, 1'b0, 64'h99, 64'h0}, "post rd");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 12'h00A;
    req1 = 1'b1; we1 = 1'b0; addr1 = 12'h123;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      e0 = (k <= 11) && (k % 3 == 2) && (!RR || ((k - 2) / 3) % 2 == 0);
      e1 = (k == 14) || (RR && (k <= 11) && (k % 3 == 2) && ((k - 2) / 3) % 2 == 1);
      chk($sformatf("tie c%0d ack0", k), 64'(ack0), 64'(e0));
      chk($sformatf("tie c%0d ack1", k), 64'(ack1), 64'(e1));
      if (k == 11) req0 = 1'b0;
    end
    req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
